evt_window_ctrl: RTL and testbench

Measurement-window controller for a bank of `NUM_CH` external event counters in the debugger. On a start pulse it clears the counters and opens an event gate for exactly `WINDOW` cycles. It then snapshots every count with a sticky per-channel wrap flag. Finally it streams one beat per channel over a valid/ready interface toward the debug transmit path, in single-shot or continuous mode.

---
 rtl/evt_window_ctrl.sv | 161 ++++++++++++++++
 tb/tb_evt_window_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evt_window_ctrl.sv
// evt_window_ctrl: opens a timed event gate over a bank of external counters,
// snapshots their values with sticky wrap flags, then streams one beat per
// channel over valid/ready (single-shot or back-to-back continuous windows).
module evt_window_ctrl #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned MAX_COUNT = 256,
   parameter int unsigned WINDOW    = 1000000,
   localparam int unsigned CW       = $clog2(MAX_COUNT),
   localparam int unsigned IW       = $clog2(NUM_CH)
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 start_in,
   input  logic                 continuous_in,
   input  logic                 abort_in,
   input  logic [NUM_CH-1:0]    evt_in,
   output logic [NUM_CH-1:0]    gated_evt_out,
   output logic                 cnt_rst_out,
   input  logic [NUM_CH*CW-1:0] count_in,
   output logic [CW-1:0]        data_out,
   output logic [IW-1:0]        chan_out,
   output logic                 ovf_out,
   output logic                 valid_out,
   input  logic                 ready_in,
   output logic                 busy_out
);

   // window counter only ever has to reach WINDOW-1
   localparam int unsigned WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

   localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_COUNT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_CH - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_COUNT = 3'd2,
      S_LATCH = 3'd3,
      S_SEND  = 3'd4
   } state_e;

   state_e                     state_q, state_d;
   logic [WW-1:0]              win_q, win_d;
   logic [IW-1:0]              idx_q, idx_d;
   logic [NUM_CH-1:0]          ovf_q, ovf_d;
   logic [NUM_CH-1:0][CW-1:0]  snap_q, snap_d;
   logic [NUM_CH-1:0][CW-1:0]  lane_c;

   logic                       gate_q, gate_d;
   logic                       cnt_rst_q, cnt_rst_d;
   logic                       valid_q, valid_d;
   logic                       busy_q, busy_d;
   logic [CW-1:0]              data_q, data_d;
   logic [IW-1:0]              chan_q, chan_d;
   logic                       ovf_out_q, ovf_out_d;

   assign lane_c = count_in;

   // event gate: combinational AND with the registered gate enable
   assign gated_evt_out = evt_in & {NUM_CH{gate_q}};

   assign cnt_rst_out = cnt_rst_q;
   assign valid_out   = valid_q;
   assign busy_out    = busy_q;
   assign data_out    = data_q;
   assign chan_out    = chan_q;
   assign ovf_out     = ovf_out_q;

   // next-state, window/channel bookkeeping, and output decode from next state
   always_comb begin
      state_d   = state_q;
      win_d     = win_q;
      idx_d     = idx_q;
      ovf_d     = ovf_q;
      snap_d    = snap_q;
      gate_d    = 1'b0;
      cnt_rst_d = 1'b0;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      data_d    = '0;
      chan_d    = '0;
      ovf_out_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_in) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            win_d   = '0;
            ovf_d   = '0;
            state_d = S_COUNT;
         end
         S_COUNT: begin
            // an accepted event on a saturated counter means it is about to wrap
            for (int i = 0; i < NUM_CH; i++) begin
               if (gated_evt_out[i] && (lane_c[i] == CNT_MAX)) ovf_d[i] = 1'b1;
            end
            if (win_q == WIN_LAST) state_d = S_LATCH;
            else                   win_d   = win_q + WW'(1);
         end
         S_LATCH: begin
            // counters have absorbed the last gated event by now
            snap_d  = lane_c;
            idx_d   = '0;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (valid_q && ready_in) begin
               if (idx_q == IDX_LAST) state_d = continuous_in ? S_CLEAR : S_IDLE;
               else                   idx_d   = idx_q + IW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort_in) state_d = S_IDLE;

      gate_d    = (state_d == S_COUNT);
      cnt_rst_d = (state_d == S_CLEAR);
      valid_d   = (state_d == S_SEND);
      busy_d    = (state_d != S_IDLE);
      if (state_d == S_SEND) begin
         chan_d    = idx_d;
         ovf_out_d = ovf_d[idx_d];
         data_d    = ovf_d[idx_d] ? CNT_MAX : snap_d[idx_d];
      end
   end

   // state and registered outputs
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q   <= S_IDLE;
         win_q     <= '0;
         idx_q     <= '0;
         ovf_q     <= '0;
         snap_q    <= '0;
         gate_q    <= 1'b0;
         cnt_rst_q <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         data_q    <= '0;
         chan_q    <= '0;
         ovf_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         win_q     <= win_d;
         idx_q     <= idx_d;
         ovf_q     <= ovf_d;
         snap_q    <= snap_d;
         gate_q    <= gate_d;
         cnt_rst_q <= cnt_rst_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         data_q    <= data_d;
         chan_q    <= chan_d;
         ovf_out_q <= ovf_out_d;
      end
   end

endmodule

// File: tb/tb_evt_window_ctrl.sv
// Bench for evt_window_ctrl: external counter bank, slot-based stimulus with an
// event-total reference model, and a scoreboard monitor on the beat stream.
module tb_evt_window_ctrl;

   localparam int unsigned NUM_CH    = 2;
   localparam int unsigned MAX_COUNT = 8;
   localparam int unsigned WINDOW    = 10;
   localparam int unsigned CW        = 3;
   localparam int unsigned IW        = 1;

   logic                 clk_in = 1'b0;
   logic                 rst_in;
   logic                 start_in;
   logic                 continuous_in;
   logic                 abort_in;
   logic                 ready_in;
   logic [NUM_CH-1:0]    evt_in;
   logic [NUM_CH-1:0]    gated_evt_out;
   logic                 cnt_rst_out;
   logic [NUM_CH*CW-1:0] count_in;
   logic [CW-1:0]        data_out;
   logic [IW-1:0]        chan_out;
   logic                 ovf_out;
   logic                 valid_out;
   logic                 busy_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int chan;
      int data;
      int ovf;
   } beat_t;

   beat_t exp_q[$];

   logic [CW-1:0] ctr [NUM_CH];

   evt_window_ctrl #(
      .NUM_CH    (NUM_CH),
      .MAX_COUNT (MAX_COUNT),
      .WINDOW    (WINDOW)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .start_in      (start_in),
      .continuous_in (continuous_in),
      .abort_in      (abort_in),
      .evt_in        (evt_in),
      .gated_evt_out (gated_evt_out),
      .cnt_rst_out   (cnt_rst_out),
      .count_in      (count_in),
      .data_out      (data_out),
      .chan_out      (chan_out),
      .ovf_out       (ovf_out),
      .valid_out     (valid_out),
      .ready_in      (ready_in),
      .busy_out      (busy_out)
   );

   always #5 clk_in = ~clk_in;

   // external modulo-MAX_COUNT counters; unaffected by rst_in
   always @(posedge clk_in) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (cnt_rst_out)           ctr[i] <= '0;
         else if (gated_evt_out[i]) ctr[i] <= CW'(ctr[i] + 1'b1);
      end
   end

   always_comb begin
      count_in = '0;
      for (int i = 0; i < NUM_CH; i++) count_in[i*CW +: CW] = ctr[i];
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // one slot: inputs change at the falling edge, sampled at the next rising edge
   task automatic drive(input logic [NUM_CH-1:0] e, input logic st, input logic ab,
                        input logic rd, input logic co);
      @(negedge clk_in);
      evt_in        = e;
      start_in      = st;
      abort_in      = ab;
      ready_in      = rd;
      continuous_in = co;
      #1;
   endtask

   // k = slots since the start edge; gate is open for k = 2 .. WINDOW+1
   function automatic logic [NUM_CH-1:0] pattern(input int mode, input int k, input int s);
      logic [NUM_CH-1:0] e;
      bit gate;
      gate = (k >= 2) && (k <= int'(WINDOW) + 1);
      e = '0;
      case (mode)
         0: begin
            e[0] = gate && (k % 2 == 0);
            e[1] = (k == 3) || (k == 5) || (k == 7);
         end
         1: begin
            e[0] = 1'b1;
            e[1] = 1'($urandom_range(0, 1));
         end
         3: begin
            if (gate) e[0] = (k == int'(WINDOW) + 1);
            else      e = '1;
         end
         4: begin
            e[0] = 1'($urandom_range(0, 1));
            e[1] = (s % 5 == 0);
         end
         default: begin
            e[0] = ($urandom % 3) == 0;
            e[1] = ($urandom % 3) == 0;
         end
      endcase
      return e;
   endfunction

   task automatic measure(input int mode, input int n_win, input int bp,
                          input bit start_in_send, input bit rst_in_send);
      int tot [NUM_CH];
      int k;
      int s;
      int w;
      int last;
      bit gate;
      logic [NUM_CH-1:0] e;
      logic st;
      logic rd;
      beat_t b;
      last = int'(WINDOW) + 2 + int'(NUM_CH) + bp;
      k = 0;
      s = 0;
      w = 0;
      foreach (tot[i]) tot[i] = 0;
      forever begin
         gate = (k >= 2) && (k <= int'(WINDOW) + 1);
         e    = pattern(mode, k, s);
         st   = ((k == 0) && (w == 0)) || (start_in_send && (k == int'(WINDOW) + 4));
         if (k < int'(WINDOW) + 3)           rd = 1'($urandom_range(0, 1));
         else if (k < int'(WINDOW) + 3 + bp) rd = 1'b0;
         else                                rd = 1'b1;
         drive(e, st, 1'b0, rd, 1'(w < n_win - 1));
         if (gate) foreach (tot[i]) tot[i] += int'(e[i]);

         chk("cnt_rst", int'(cnt_rst_out), int'(k == 1));
         chk("gated_evt", int'(gated_evt_out), gate ? int'(e) : 0);
         chk("busy", int'(busy_out), int'((k >= 1) || (w > 0)));
         chk("valid_timing", int'(valid_out), int'(k >= int'(WINDOW) + 3));
         if ((k >= int'(WINDOW) + 3) && (k < int'(WINDOW) + 3 + bp))
            chk("bp_chan", int'(chan_out), 0);

         // totals are final once the last gate-open slot has been driven
         if (k == int'(WINDOW) + 1) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
               b.chan = i;
               b.ovf  = int'(tot[i] >= int'(MAX_COUNT));
               b.data = (tot[i] >= int'(MAX_COUNT)) ? int'(MAX_COUNT) - 1 : tot[i];
               exp_q.push_back(b);
            end
         end

         if (rst_in_send && (k == int'(WINDOW) + 3)) begin
            #2 rst_in = 1'b1;
            #1;
            chk("arst_valid", int'(valid_out), 0);
            chk("arst_busy", int'(busy_out), 0);
            chk("arst_data", int'(data_out), 0);
            chk("arst_chan", int'(chan_out), 0);
            chk("arst_ovf", int'(ovf_out), 0);
            @(negedge clk_in);
            @(negedge clk_in);
            rst_in = 1'b0;
            exp_q.delete();
            break;
         end

         if (k == last) begin
            if (w < n_win - 1) begin
               w++;
               k = 0;
               foreach (tot[i]) tot[i] = 0;
            end else begin
               break;
            end
         end
         k++;
         s++;
      end
      drive('0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("idle_busy", int'(busy_out), 0);
      chk("idle_valid", int'(valid_out), 0);
   endtask

   // scoreboard monitor: pops one expected beat per accepted handshake
   initial begin : monitor
      bit            hold_v;
      logic [CW-1:0] hd;
      logic [IW-1:0] hc;
      logic          ho;
      beat_t         b;
      hold_v = 1'b0;
      hd = '0;
      hc = '0;
      ho = 1'b0;
      forever begin
         @(negedge clk_in);
         #1;
         if (rst_in) begin
            hold_v = 1'b0;
         end else begin
            if (hold_v) begin
               chk("valid_held", int'(valid_out), 1);
               if (valid_out) begin
                  chk("data_stable", int'(data_out), int'(hd));
                  chk("chan_stable", int'(chan_out), int'(hc));
                  chk("ovf_stable", int'(ovf_out), int'(ho));
               end
            end
            if (valid_out && ready_in) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: chan %0d data %0d ovf %0d, none expected at %0t",
                           chan_out, data_out, ovf_out, $time);
               end else begin
                  b = exp_q.pop_front();
                  chk("beat_chan", int'(chan_out), b.chan);
                  chk("beat_data", int'(data_out), b.data);
                  chk("beat_ovf", int'(ovf_out), b.ovf);
               end
               hold_v = 1'b0;
            end else if (valid_out) begin
               hold_v = 1'b1;
               hd = data_out;
               hc = chan_out;
               ho = ovf_out;
            end else begin
               hold_v = 1'b0;
            end
         end
      end
   end

   // test sequence
   initial begin
      rst_in        = 1'b1;
      start_in      = 1'b0;
      abort_in      = 1'b0;
      continuous_in = 1'b0;
      ready_in      = 1'b1;
      evt_in        = '1;
      repeat (2) @(negedge clk_in);
      #1;
      chk("rst_valid", int'(valid_out), 0);
      chk("rst_busy", int'(busy_out), 0);
      chk("rst_cnt_rst", int'(cnt_rst_out), 0);
      chk("rst_data", int'(data_out), 0);
      chk("rst_chan", int'(chan_out), 0);
      chk("rst_ovf", int'(ovf_out), 0);
      chk("rst_gated", int'(gated_evt_out), 0);
      @(negedge clk_in);
      rst_in = 1'b0;
      evt_in = '0;

      measure(0, 1, 0, 1'b0, 1'b0);   // count and readout: 5 / 3
      measure(1, 1, 0, 1'b0, 1'b0);   // ch0 wraps: 7 with ovf
      measure(2, 1, 5, 1'b0, 1'b0);   // backpressure on beat 0
      measure(3, 1, 0, 1'b1, 1'b0);   // gate boundaries, start during SEND
      measure(4, 3, 0, 1'b0, 1'b0);   // continuous windows

      // abort in the fourth COUNT cycle
      drive('1, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= int'(WINDOW) + 8; k++) begin
         drive('1, 1'b0, 1'(k == 5), 1'b1, 1'b0);
         if (k == 4) begin
            chk("abort_pre_busy", int'(busy_out), 1);
            chk("abort_pre_gate", int'(gated_evt_out), 3);
         end
         if (k >= 6) begin
            chk("abort_busy", int'(busy_out), 0);
            chk("abort_gate", int'(gated_evt_out), 0);
            chk("abort_valid", int'(valid_out), 0);
         end
      end

      measure(2, 1, 3, 1'b0, 1'b1);   // async reset mid-SEND
      measure(0, 1, 0, 1'b0, 1'b0);   // fresh start after reset
      for (int r = 0; r < 4; r++) measure(2, 1, int'($urandom_range(0, 3)), 1'b0, 1'b0);

      repeat (3) drive('0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
